// File: rtl/ocm_stream_loader.sv
// rtl/ocm_stream_loader.sv - stream-to-OCM write loader; define OCM_LOADER_CHECKSUM_EN to add the checksum output
module ocm_stream_loader #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [ADDR_W-1:0]   base_addr,
    input  logic [ADDR_W:0]     word_count,
    input  logic                abort,
    input  logic [DATA_W-1:0]   snk_data,
    input  logic                snk_valid,
    output logic                snk_ready,
    output logic [ADDR_W-1:0]   ocm_address,
    output logic [DATA_W/8-1:0] ocm_byteenable,
    output logic                ocm_chipselect,
    output logic                ocm_write,
    output logic [DATA_W-1:0]   ocm_writedata,
    output logic                ocm_clken,
    output logic                busy,
    output logic                done
`ifdef OCM_LOADER_CHECKSUM_EN
    ,
    output logic [DATA_W-1:0]   checksum
`endif
);

    typedef enum logic [1:0] {IDLE, LOAD, FINISH} state_t;

    localparam logic [ADDR_W:0] MAX_COUNT = {1'b1, {ADDR_W{1'b0}}};

    state_t            state, state_next;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W:0]   remaining;
    logic [ADDR_W:0]   clamped;
    logic              accept;
    logic              take_start;

    assign clamped        = (word_count > MAX_COUNT) ? MAX_COUNT : word_count;
    assign take_start     = (state == IDLE) && start;
    assign snk_ready      = (state == LOAD) && (remaining != '0);
    assign accept         = snk_valid && snk_ready;
    assign busy           = (state == LOAD);
    assign ocm_clken      = 1'b1;
    assign ocm_byteenable = '1;

    // Abort is tested before completion so a final beat with abort never reaches FINISH.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = (clamped == '0) ? FINISH : LOAD;
                end
            end
            LOAD: begin
                if (abort) begin
                    state_next = IDLE;
                end else if (accept && (remaining == {{ADDR_W{1'b0}}, 1'b1})) begin
                    state_next = FINISH;
                end
            end
            FINISH:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            addr           <= '0;
            remaining      <= '0;
            ocm_chipselect <= 1'b0;
            ocm_write      <= 1'b0;
            ocm_address    <= '0;
            ocm_writedata  <= '0;
            done           <= 1'b0;
        end else begin
            state          <= state_next;
            ocm_chipselect <= accept;
            ocm_write      <= accept;
            done           <= (state == FINISH);
            if (accept) begin
                ocm_address   <= addr;
                ocm_writedata <= snk_data;
            end
            if (take_start) begin
                addr      <= base_addr;
                remaining <= clamped;
            end else if (accept) begin
                addr      <= addr + 1'b1;
                remaining <= remaining - 1'b1;
            end
        end
    end

`ifdef OCM_LOADER_CHECKSUM_EN
    // Accumulated at acceptance so the sum already covers the last word when done pulses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            checksum <= '0;
        end else if (take_start) begin
            checksum <= '0;
        end else if (accept) begin
            checksum <= checksum + snk_data;
        end
    end
`endif

endmodule

// File: doc/ocm_stream_loader.md
OCM_STREAM_LOADER -- requirements
Module: ocm_stream_loader

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 7, meaning the OCM word-address width (128 words).
REQ-002 The block SHALL have parameter DATA_W, default 32, meaning the OCM data width; byteenable width is DATA_W/8.
REQ-003 Port clk, input, 1 bit: the single clock for all logic.
REQ-004 Port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 Port start, input, 1 bit: single-cycle request to begin a load; sampled only in IDLE.
REQ-006 Port base_addr, input, ADDR_W bits: first OCM word address, latched on an accepted start.
REQ-007 Port word_count, input, ADDR_W+1 bits: number of words to load, latched on an accepted start.
REQ-008 Port abort, input, 1 bit: terminates a load in progress.
REQ-009 Port snk_data, input, DATA_W bits: stream payload.
REQ-010 Port snk_valid, input, 1 bit: snk_data is valid.
REQ-011 Port snk_ready, output, 1 bit: the block accepts a word this cycle.
REQ-012 Ports ocm_address (ADDR_W), ocm_byteenable (DATA_W/8), ocm_chipselect (1), ocm_write (1), ocm_writedata (DATA_W), ocm_clken (1), all outputs: Avalon-MM write master into the single-port OCM.
REQ-013 Port busy, output, 1 bit: asserted while in LOAD.
REQ-014 Port done, output, 1 bit: single-cycle pulse at the end of a completed load.

Function
REQ-015 The FSM SHALL have states IDLE, LOAD and FINISH.
REQ-016 In IDLE, start=1 SHALL latch base_addr and a clamped count (values >128 become 128), then transition to LOAD; if the latched count is 0, the FSM SHALL go to FINISH instead.
REQ-017 A start asserted outside IDLE SHALL be ignored.
REQ-018 snk_ready SHALL be 1 only in LOAD while the remaining count is nonzero.
REQ-019 Each snk_valid&snk_ready beat SHALL produce exactly one registered write on the next cycle: ocm_chipselect=ocm_write=1, ocm_writedata=beat data, ocm_address=current address, ocm_byteenable all ones.
REQ-020 ocm_chipselect and ocm_write SHALL be 0 in every cycle that does not follow an accepted beat.
REQ-021 The address SHALL increment by 1 per accepted beat and wrap modulo 2^ADDR_W (127 to 0).
REQ-022 When the final beat is accepted, the FSM SHALL move to FINISH; done SHALL pulse in FINISH, one cycle after the final write, and the FSM SHALL return to IDLE on the following cycle.
REQ-023 For a zero count, done SHALL pulse exactly 2 cycles after start, with no OCM writes.
REQ-024 abort=1 in LOAD SHALL return the FSM to IDLE on the next edge without a done pulse; a beat accepted in the same cycle SHALL still be written; abort has priority over completion when both occur in the same cycle.
REQ-025 ocm_clken SHALL be held at 1.
REQ-026 Throughput SHALL be one word per cycle with snk_valid held high.

Reset
REQ-027 While reset is high, the FSM SHALL be in IDLE and all outputs SHALL be 0 (except ocm_clken=1 and ocm_byteenable all ones), including during a load in progress; no partial write may be issued after reset.

Configuration
REQ-028 With macro OCM_LOADER_CHECKSUM_EN defined, the block SHALL add output checksum (DATA_W bits), a modulo-2^DATA_W sum of all words written since the last accepted start; it SHALL be cleared on start and on reset, and SHALL be stable when done pulses.
REQ-029 Without OCM_LOADER_CHECKSUM_EN, the checksum port and its logic SHALL be absent; all other behaviour is unchanged.

Verification
REQ-030 base=0x10, count=4, data 0xA0..0xA3 streamed back-to-back -> writes to addresses 0x10..0x13 on consecutive cycles, done 1 cycle after the last write, checksum=0x00000286.
REQ-031 base=0x7E, count=3 -> writes to addresses 0x7E, 0x7F, 0x00.
REQ-032 count=0 -> no ocm_write, done pulses 2 cycles after start; count=200 -> exactly 128 writes.
REQ-033 snk_valid toggling 1,0,1,0 with count=2 -> writes occur only after valid beats, with no gaps or duplicate writes; a start issued mid-load is ignored.
REQ-034 Abort after 2 of 5 beats -> 2 writes, no done, busy=0 on the next cycle; async reset after beat 1 -> all outputs 0 immediately and no further writes.
